mul_div_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute stage of the MIPS datapath.
- Fed by register-file read data 1/2; HI/LO feed the write-back mux for MFHI/MFLO.
- Control unit stalls PC update while busy=1.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_if.sv | 33 +++
 rtl/mdu_abs_neg.sv | 16 +
 rtl/mul_div_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mdu_pkg
// Description : Shared encodings and sizing for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Iteration counter must hold 0..WIDTH-1 with headroom for the compare.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MDU_CNT_W = cnt_width(MDU_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mdu_if
// Description : Execute-stage bundle between the datapath and the MDU.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_abs_neg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mdu_abs_neg
// Description : Conditional two's-complement negate (magnitude / sign fix).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);
  assign result = neg ? (~value + W'(1)) : value;
endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : mul_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
//               One shift-add or restoring-divide step per cycle.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state;
  state_e             state_next;
  logic               is_div_q;
  logic               neg_res;    // product / quotient sign
  logic               neg_rem;    // remainder follows the dividend
  logic               zero_q;     // divide by zero pending
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // {upper, lower} working register
  logic [CNT_W-1:0]   count;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand decode at launch
  op_e              op_in;
  logic             is_signed_in;
  logic             is_div_in;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign op_in        = op_e'(bus.op);
  assign is_signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign is_div_in    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign sign_a       = is_signed_in & bus.a[WIDTH-1];
  assign sign_b       = is_signed_in & bus.b[WIDTH-1];
  assign div_zero_in  = is_div_in && (bus.b == '0);

  mdu_abs_neg #(.W(WIDTH)) u_abs_a (.value(bus.a), .neg(sign_a), .result(abs_a));
  mdu_abs_neg #(.W(WIDTH)) u_abs_b (.value(bus.b), .neg(sign_b), .result(abs_b));

  // Sign fix applied to the unsigned result at commit
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mdu_abs_neg #(.W(2*WIDTH)) u_fix_prod (.value(acc), .neg(neg_res), .result(prod_fix));
  mdu_abs_neg #(.W(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .neg(neg_res), .result(quo_fix));
  mdu_abs_neg #(.W(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem), .result(rem_fix));

  // One iteration step for each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic               take;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;

  // Shift-add multiply and restoring divide step, evaluated every cycle
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    take      = rem_shift >= {1'b0, opnd};
    rem_sub   = rem_shift[WIDTH-1:0] - opnd;
    div_next  = {(take ? rem_sub : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], take};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = div_zero_in ? COMMIT : CALC;
      CALC:    if (count == CNT_W'(WIDTH - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_q   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state == COMMIT);
      dbz_q  <= (state == COMMIT) && zero_q;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            is_div_q <= is_div_in;
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            zero_q   <= div_zero_in;
            count    <= '0;
            // Dividend / multiplier sit in the lower half; upper half cleared
            if (is_div_in) begin
              opnd <= abs_b;
              acc  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd <= abs_a;
              acc  <= {{WIDTH{1'b0}}, abs_b};
            end
          end
        end
        CALC: begin
          acc   <= is_div_q ? div_next : mul_next;
          count <= count + CNT_W'(1);
        end
        COMMIT: begin
          if (!zero_q) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
`default_nettype wire
